// File: rtl/day8_sort_sequencer_if.sv
// Window request/response channel between the sort sequencer (master) and the sort engine (slave).
// A request is taken on valid & ready; the engine later pulses win_done for that window.
interface day8_sort_sequencer_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              win_valid;
    logic              win_ready;
    logic [ADDR_W-1:0] win_addr;
    logic [6:0]        win_len;
    logic              win_done;
    logic              win_swapped;

    modport master (
        output win_valid,
        output win_addr,
        output win_len,
        input  win_ready,
        input  win_done,
        input  win_swapped
    );

    modport slave (
        input  win_valid,
        input  win_addr,
        input  win_len,
        output win_ready,
        output win_done,
        output win_swapped
    );
endinterface

// File: rtl/day8_sort_sequencer.sv
// Steps overlapping windows across the pair-distance table, one at a time, and repeats whole
// passes until a pass makes no swaps or the pass cap is reached.
module day8_sort_sequencer #(
    parameter int unsigned TABLE_HEIGHT = 499500,
    parameter int unsigned WINDOW       = 62,
    parameter int unsigned OVERLAP      = 4,
    parameter int unsigned MAX_PASSES   = 8612,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned PASS_W       = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    day8_sort_sequencer_if.master win,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [PASS_W-1:0]     pass_count
);
    localparam int unsigned SumW = ADDR_W + 1;
    localparam logic [SumW-1:0]   TableH  = SumW'(TABLE_HEIGHT);
    localparam logic [SumW-1:0]   WinW    = SumW'(WINDOW);
    localparam logic [SumW-1:0]   Step    = SumW'(WINDOW - OVERLAP);
    localparam logic [PASS_W-1:0] MaxPass = PASS_W'(MAX_PASSES);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StPassEnd, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        len_q, len_d;
    logic              valid_q, valid_d;
    logic              dirty_q, dirty_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              conv_q, conv_d;
    logic [PASS_W-1:0] pass_q, pass_d;

    logic [SumW-1:0] addr_ext, addr_step;
    logic            last_win;

    // Window length is the table remainder, clipped to the engine width.
    function automatic logic [6:0] len_of(logic [SumW-1:0] a);
        logic [SumW-1:0] rem;
        rem = TableH - a;
        return 7'((rem > WinW) ? WinW : rem);
    endfunction

    assign addr_ext  = {1'b0, addr_q};
    assign addr_step = addr_ext + Step;
    assign last_win  = (addr_ext + WinW) >= TableH;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        conv_d  = conv_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    addr_d  = '0;
                    len_d   = len_of('0);
                    pass_d  = '0;
                    dirty_d = 1'b0;
                    conv_d  = 1'b0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            StIssue: begin
                if (win.win_ready) begin
                    state_d = StWait;
                    valid_d = 1'b0;
                end
            end
            StWait: begin
                if (win.win_done) begin
                    dirty_d = dirty_q | win.win_swapped;
                    if (last_win) begin
                        state_d = StPassEnd;
                    end else begin
                        state_d = StIssue;
                        addr_d  = addr_step[ADDR_W-1:0];
                        len_d   = len_of(addr_step);
                        valid_d = 1'b1;
                    end
                end
            end
            StPassEnd: begin
                if (pass_q != MaxPass) pass_d = pass_q + 1'b1;
                if (!dirty_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    conv_d  = 1'b1;
                end else if ((pass_q + 1'b1) == MaxPass) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    conv_d  = 1'b0;
                end else begin
                    state_d = StIssue;
                    addr_d  = '0;
                    len_d   = len_of('0);
                    dirty_d = 1'b0;
                    valid_d = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            pass_q  <= pass_d;
        end
    end

    assign win.win_valid = valid_q;
    assign win.win_addr  = addr_q;
    assign win.win_len   = len_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign converged     = conv_q;
    assign pass_count    = pass_q;
endmodule
